// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory refill arbiter.
//   - arb_state_e : arbiter FSM states
//   - REQ_ICACHE / REQ_DCACHE : requester indices into req_read / req_valid
//   - default geometry (32-bit address, 64-byte line, 64-bit beat) and
//     helpers that derive line/beat/offset sizes from any geometry
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        DELIVER = 2'd3
    } arb_state_e;

    localparam int REQ_ICACHE = 0;
    localparam int REQ_DCACHE = 1;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int LINE_BYTES_DEF = 64;
    localparam int BEAT_WIDTH_DEF = 64;

    function automatic int line_bits_of(input int line_bytes);
        return line_bytes * 8;
    endfunction

    function automatic int beats_of(input int line_bytes, input int beat_width);
        return (line_bytes * 8) / beat_width;
    endfunction

    localparam int LINE_BITS   = line_bits_of(LINE_BYTES_DEF);
    localparam int BEATS       = beats_of(LINE_BYTES_DEF, BEAT_WIDTH_DEF);
    localparam int OFFSET_BITS = $clog2(LINE_BYTES_DEF);

endpackage

// File: rtl/mem_refill_arbiter_line_assembler.sv
// line_assembler: collects memory response beats into one cache line.
//   clk, rst_n  : clock, async active-low reset
//   clear       : restart at beat 0 (asserted on the read-command handshake)
//   beat_valid  : beat_data is a valid beat to store
//   beat_data   : response beat, lowest address first
//   line        : assembled line; holds until a later beat overwrites it
//   last_beat   : the next stored beat completes the line
module line_assembler
    import mem_arb_pkg::*;
#(
    parameter int N_BEATS    = BEATS,
    parameter int BEAT_WIDTH = BEAT_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          beat_valid,
    input  logic [BEAT_WIDTH-1:0]         beat_data,
    output logic [N_BEATS*BEAT_WIDTH-1:0] line,
    output logic                          last_beat
);

    localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    logic [CNT_W-1:0]              beat_cnt_q, beat_cnt_d;
    logic [N_BEATS*BEAT_WIDTH-1:0] line_q, line_d;

    assign last_beat = (beat_cnt_q == CNT_W'(N_BEATS - 1));
    assign line      = line_q;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        if (clear) begin
            beat_cnt_d = '0;
        end else if (beat_valid) begin
            line_d[beat_cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            line_q     <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            line_q     <= line_d;
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one memory read port between icache and dcache
// line refills, round-robin when both miss at once.
//   clk, rst_n      : clock, async active-low reset
//   req_read[1:0]   : refill request (0=icache, 1=dcache), held until req_valid
//   req_addr        : miss address per requester, [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data        : assembled line, shared by both requesters
//   req_valid[1:0]  : one-cycle pulse, req_data valid for that requester
//   mem_req_valid/ready/addr : line-aligned read command handshake
//   mem_rsp_valid/data       : response beats, no backpressure
//   busy            : FSM not in IDLE
//   rsp_err         : sticky, a beat arrived outside COLLECT
//
//   state   | meaning
//   IDLE    | wait for a request; grant and latch the aligned address
//   ISSUE   | hold the read command until memory accepts it
//   COLLECT | store BEATS response beats into the line register
//   DELIVER | one cycle: pulse req_valid if the winner still wants the line
module mem_refill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF,
    parameter int BEAT_WIDTH = BEAT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_read,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    output logic [LINE_BYTES*8-1:0] req_data,
    output logic [1:0]              req_valid,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic                    mem_rsp_valid,
    input  logic [BEAT_WIDTH-1:0]   mem_rsp_data,
    output logic                    busy,
    output logic                    rsp_err
);

    localparam int NB  = beats_of(LINE_BYTES, BEAT_WIDTH);
    localparam int OFS = $clog2(LINE_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-OFS){1'b1}}, {OFS{1'b0}}};

    arb_state_e            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic                  busy_q, busy_d;

    logic asm_clear, asm_beat, asm_last;

    assign asm_clear = (state_q == ISSUE) && mem_req_ready;
    assign asm_beat  = (state_q == COLLECT) && mem_rsp_valid;

    line_assembler #(
        .N_BEATS    (NB),
        .BEAT_WIDTH (BEAT_WIDTH)
    ) u_line_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .beat_valid (asm_beat),
        .beat_data  (mem_rsp_data),
        .line       (req_data),
        .last_beat  (asm_last)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        req_valid    = 2'b00;
        // Beats outside COLLECT are dropped; only the error flag records them.
        rsp_err_d    = rsp_err_q | (mem_rsp_valid && (state_q != COLLECT));

        case (state_q)
            IDLE: begin
                if (|req_read) begin
                    if (req_read == 2'b11) grant_d = ~last_grant_q;
                    else                   grant_d = req_read[REQ_DCACHE];
                    addr_d = (grant_d ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                      : req_addr[0 +: ADDR_WIDTH]) & ALIGN_MASK;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) state_d = COLLECT;
            end
            COLLECT: begin
                if (asm_beat && asm_last) state_d = DELIVER;
            end
            DELIVER: begin
                // A requester that withdrew gets no pulse; the slot still counts for round-robin.
                req_valid[grant_q] = req_read[grant_q];
                last_grant_d       = grant_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mem_req_valid_d = (state_d == ISSUE);
        busy_d          = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            grant_q         <= 1'b0;
            last_grant_q    <= 1'b1;
            addr_q          <= '0;
            rsp_err_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            addr_q          <= addr_d;
            rsp_err_q       <= rsp_err_d;
            mem_req_valid_q <= mem_req_valid_d;
            busy_q          <= busy_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = addr_q;
    assign busy          = busy_q;
    assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
module tb_mem_refill_arbiter;

    localparam int AW    = 32;
    localparam int LBITS = 512;
    localparam int BW    = 64;
    localparam int NB    = LBITS / BW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        req_read = 2'b00;
    logic [2*AW-1:0]   req_addr = '0;
    logic [LBITS-1:0]  req_data;
    logic [1:0]        req_valid;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_rsp_valid = 1'b0;
    logic [BW-1:0]     mem_rsp_data = '0;
    logic              busy;
    logic              rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    // round-robin model state: who was served last (reset favours icache next)
    int          last_g;
    logic [1:0]  pend;
    logic [AW-1:0] a_model [2];

    mem_refill_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_read      (req_read),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy),
        .rsp_err       (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [LBITS-1:0] obs, input logic [LBITS-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req_data"},  req_data, '0);
        chk({tag, "_req_valid"}, req_valid, 2'b00);
        chk({tag, "_mem_valid"}, mem_req_valid, 1'b0);
        chk({tag, "_mem_addr"},  mem_req_addr, '0);
        chk({tag, "_busy"},      busy, 1'b0);
        chk({tag, "_rsp_err"},   rsp_err, 1'b0);
    endtask

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a - (a % 64);
    endfunction

    // Acts as memory for one refill: waits for the command, stalls ready for
    // dly cycles, returns NB beats (seed+i) with gap idle cycles before each,
    // and checks the delivered line. drop_after >= 0 withdraws drop_mask
    // requests right after that beat.
    task automatic serve(input string tag, input int dly, input int gap,
                         input logic [AW-1:0] exp_addr, input logic [1:0] exp_vld,
                         input logic [BW-1:0] seed, input int drop_after,
                         input logic [1:0] drop_mask);
        logic [LBITS-1:0] exp_line;
        int n;
        exp_line = '0;
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cmd_seen"}, mem_req_valid, 1'b1);
        chk({tag, "_cmd_addr"}, mem_req_addr, exp_addr);
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, mem_req_valid, 1'b1);
            chk({tag, "_stall_addr"}, mem_req_addr, exp_addr);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk({tag, "_cmd_done"}, mem_req_valid, 1'b0);
        for (int b = 0; b < NB; b++) begin
            for (int g = 0; g < gap; g++) begin
                chk({tag, "_gap_busy"}, busy, 1'b1);
                chk({tag, "_gap_no_valid"}, req_valid, 2'b00);
                @(negedge clk);
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = seed + BW'(b);
            exp_line[b*BW +: BW] = seed + BW'(b);
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (b == drop_after) req_read = req_read & ~drop_mask;
            if (b != NB - 1) begin
                chk({tag, "_partial_no_valid"}, req_valid, 2'b00);
                chk({tag, "_busy"}, busy, 1'b1);
            end
        end
        chk({tag, "_req_valid"}, req_valid, exp_vld);
        chk({tag, "_req_data"}, req_data, exp_line);
        @(negedge clk);
        chk({tag, "_pulse_end"}, req_valid, 2'b00);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_data_held"}, req_data, exp_line);
    endtask

    initial begin
        logic [LBITS-1:0] ln;
        int n;
        int g;
        logic [1:0] add;

        // reset
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // single icache refill, command accepted at once, beats back-to-back
        req_addr[0 +: AW] = 32'h0000_1234;
        req_read = 2'b01;
        @(negedge clk);
        chk("t1_issue_latency", mem_req_valid, 1'b1);
        serve("t1", 0, 0, 32'h0000_1200, 2'b01, 64'h0, -1, 2'b00);
        ln = req_data;
        chk("t1_first_beat", ln[63:0], 64'h0);
        chk("t1_last_beat", ln[511:448], 64'h7);
        req_read = 2'b00;

        // both request together after reset: icache first, then dcache
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_addr = {32'h0000_2000, 32'h0000_1000};
        req_read = 2'b11;
        serve("t2_icache", 5, 0, 32'h0000_1000, 2'b01, 64'h100, -1, 2'b00);
        req_read = 2'b10;
        serve("t2_dcache", 0, 3, 32'h0000_2000, 2'b10, 64'h200, -1, 2'b00);
        req_read = 2'b00;

        // dcache withdraws mid-refill: line consumed, no pulse
        req_addr[AW +: AW] = 32'h0000_307F;
        req_read = 2'b10;
        serve("t3_drop", 1, 1, 32'h0000_3040, 2'b00, 64'h300, 3, 2'b10);
        chk("t3_mem_idle", mem_req_valid, 1'b0);

        // stray beat in IDLE sets the sticky error
        chk("t4_err_before", rsp_err, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hDEAD;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("t4_err_set", rsp_err, 1'b1);
        chk("t4_still_idle", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", rsp_err, 1'b1);

        // reset in the middle of a refill
        req_addr[0 +: AW] = 32'h0000_4000;
        req_read = 2'b01;
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_cmd_seen", mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 64'hA0 + 64'(b);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("t5_mid_reset");
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        rst_n = 1'b1;
        serve("t5_restart", 0, 0, 32'h0000_4000, 2'b01, 64'h500, -1, 2'b00);
        req_read = 2'b00;

        // randomized refills against the round-robin model
        last_g = 0;
        pend = 2'b00;
        for (int it = 0; it < 12; it++) begin
            add = 2'($urandom_range(0, 3)) & ~pend;
            if (pend == 2'b00 && add == 2'b00) add = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                if (add[r]) begin
                    a_model[r] = $urandom;
                    req_addr[r*AW +: AW] = a_model[r];
                end
            end
            pend = pend | add;
            req_read = pend;
            if (pend == 2'b11) g = 1 - last_g;
            else               g = pend[1] ? 1 : 0;
            serve("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  align(a_model[g]), 2'(1 << g), {$urandom, $urandom}, -1, 2'b00);
            pend[g] = 1'b0;
            req_read = pend;
            last_g = g;
        end
        req_read = 2'b00;
        repeat (2) @(negedge clk);
        chk("final_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
